alu64_seq: RTL and testbench

ALU64_SEQ -- requirements
Module: alu64_seq

---
 rtl/alu64_seq.sv | 127 ++++++++++++
 tb/tb_alu64_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu64_seq.sv
// rtl/alu64_seq.sv - two-stage Y86 OPq ALU with valid/ready handshake; define ALU64_SEQ_CC_EN for zf/sf/of outputs
module alu64_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bad_op
`ifdef ALU64_SEQ_CC_EN
    ,
    output logic             zf,
    output logic             sf,
    output logic             of
`endif
);

    logic             s1_valid;
    logic [3:0]       s1_ifun;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_bad;

    logic             s1_adv;
    logic             in_fire;
    logic [WIDTH-1:0] calc_result;
    logic             calc_bad;

    // S1 may move on whenever S2 is empty or being drained this same cycle.
    assign s1_adv   = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        calc_result = '0;
        calc_bad    = 1'b0;
        case (s1_ifun)
            4'd0:    calc_result = s1_b + s1_a;
            4'd1:    calc_result = s1_b - s1_a;
            4'd2:    calc_result = s1_b & s1_a;
            4'd3:    calc_result = s1_b ^ s1_a;
            default: calc_bad    = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_ifun   <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_bad    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_ifun  <= ifun;
                s1_a     <= a;
                s1_b     <= b;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid  <= 1'b1;
                s2_result <= calc_result;
                s2_bad    <= calc_bad;
            end else if (out_ready) begin
                s2_valid  <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign bad_op    = s2_bad;

`ifdef ALU64_SEQ_CC_EN
    logic calc_zf;
    logic calc_sf;
    logic calc_of;
    logic s2_zf;
    logic s2_sf;
    logic s2_of;

    // Flags stay clear for an illegal ifun even though its zero result would set zf.
    always_comb begin
        calc_zf = !calc_bad && (calc_result == '0);
        calc_sf = calc_result[WIDTH-1];
        calc_of = 1'b0;
        case (s1_ifun)
            4'd0:    calc_of = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                               (calc_result[WIDTH-1] != s1_a[WIDTH-1]);
            4'd1:    calc_of = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                               (calc_result[WIDTH-1] != s1_b[WIDTH-1]);
            default: calc_of = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_zf <= 1'b0;
            s2_sf <= 1'b0;
            s2_of <= 1'b0;
        end else if (s1_adv) begin
            s2_zf <= calc_zf;
            s2_sf <= calc_sf;
            s2_of <= calc_of;
        end
    end

    assign zf = s2_zf;
    assign sf = s2_sf;
    assign of = s2_of;
`endif

endmodule

// File: tb/tb_alu64_seq.sv
// tb/tb_alu64_seq.sv - randomized and directed bench for alu64_seq with an arithmetic reference model
module tb_alu64_seq;

    typedef struct packed {
        logic [63:0] r;
        logic        bad;
        logic        z;
        logic        s;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;
    logic        bad_op;
    exp_t        obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef ALU64_SEQ_CC_EN
    logic zf, sf, of;
    assign obs = {result, bad_op, zf, sf, of};
`else
    assign obs = {result, bad_op, 3'b000};
`endif

    alu64_seq #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifun      (ifun),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bad_op    (bad_op)
`ifdef ALU64_SEQ_CC_EN
        ,
        .zf        (zf),
        .sf        (sf),
        .of        (of)
`endif
    );

    // Reference: evaluate in 65-bit signed arithmetic; overflow means the true value does not fit 64 bits.
    function automatic exp_t model(input logic [3:0] f, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        logic signed [64:0] wide;
        e    = '0;
        wide = '0;
        case (f)
            4'd0:    wide = $signed({y[63], y}) + $signed({x[63], x});
            4'd1:    wide = $signed({y[63], y}) - $signed({x[63], x});
            4'd2:    wide = {1'b0, y & x};
            4'd3:    wide = {1'b0, y ^ x};
            default: e.bad = 1'b1;
        endcase
        if (!e.bad) begin
            e.r = wide[63:0];
            e.z = (e.r == 64'd0);
            e.s = e.r[63];
            e.o = (f <= 4'd1) && (wide[64] != wide[63]);
        end
        return e;
    endfunction

    function automatic exp_t vis(input exp_t e);
        exp_t v;
        v = e;
`ifndef ALU64_SEQ_CC_EN
        v.z = 1'b0;
        v.s = 1'b0;
        v.o = 1'b0;
`endif
        return v;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ifun = 4'd0; a = 64'd1; b = 64'd2; out_ready = 1'b1;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || obs !== exp_t'(0)) begin
            fails++;
            $display("FAIL reset_state out_valid=%b obs=%h required out_valid=0 obs=0", out_valid, obs);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_ignores_request cycle=%0d out_valid=%b required=0", i, out_valid);
            end
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  df[4]  = '{4'd2, 4'd0, 4'd1, 4'd7};
        logic [63:0] da[4]  = '{64'd69, 64'd1, 64'd5, 64'd44};
        logic [63:0] db[4]  = '{64'hFFFF_FFFF_FFFF_FFA0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd4, 64'd4};
        logic [63:0] dr[4]  = '{64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [3:0]  dfl[4] = '{4'b0100, 4'b0011, 4'b0010, 4'b1000};
        exp_t        want;
        for (int i = 0; i < 4; i++) begin
            want = vis({dr[i], dfl[i]});
            in_valid = 1'b1; ifun = df[i]; a = da[i]; b = db[i]; out_ready = 1'b1;
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL single_in_ready vec=%0d got=%b required=1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL single_latency_early vec=%0d out_valid=%b required=0", i, out_valid);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || obs !== want) begin
                fails++;
                $display("FAIL single_result vec=%0d out_valid=%b obs=%h required out_valid=1 obs=%h",
                         i, out_valid, obs, want);
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drained out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; ifun = 4'd2; a = 64'd14; b = 64'd9;
        tick();
        a = 64'hFFFF_FFFF_FFFF_FFA1; b = 64'd23;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 64'd8 || bad_op !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first out_valid=%b result=%0d bad_op=%b required 1/8/0", out_valid, result, bad_op);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || result !== 64'd1 || bad_op !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second out_valid=%b result=%0d bad_op=%b required 1/1/0", out_valid, result, bad_op);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_duplicate out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  f[3];
        logic [63:0] oa[3];
        logic [63:0] ob[3];
        exp_t        q[$];
        exp_t        held;
        exp_t        e;
        int          idx = 0;
        int          delivered = 0;
        logic        acc;
        for (int i = 0; i < 3; i++) begin
            f[i] = 4'($urandom_range(0, 3)); oa[i] = pick(); ob[i] = pick();
        end
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin ifun = f[idx]; a = oa[idx]; b = ob[idx]; end
            #1;
            acc = in_valid && in_ready;
            if (acc) q.push_back(model(ifun, a, b));
            tick();
            if (acc) idx++;
        end
        tests++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept_count accepted=%0d in_ready=%b required 2/0", idx, in_ready);
        end
        tests++;
        if (out_valid !== 1'b1 || q.size() == 0 || obs !== vis(q[0])) begin
            fails++;
            $display("FAIL bp_head out_valid=%b obs=%h required out_valid=1 obs=%h",
                     out_valid, obs, (q.size() != 0) ? vis(q[0]) : exp_t'(0));
        end
        held = obs;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || obs !== held || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b obs=%h in_ready=%b required 1/%h/0",
                         cyc, out_valid, obs, in_ready, held);
            end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin ifun = f[idx]; a = oa[idx]; b = ob[idx]; end
            #1;
            if (out_valid && out_ready) begin
                delivered++;
                tests++;
                e = (q.size() != 0) ? q.pop_front() : exp_t'(0);
                if (obs !== vis(e)) begin
                    fails++;
                    $display("FAIL bp_release_order n=%0d obs=%h required=%h", delivered, obs, vis(e));
                end
            end
            acc = in_valid && in_ready;
            if (acc) q.push_back(model(ifun, a, b));
            tick();
            if (acc) idx++;
        end
        tests++;
        if (delivered !== 3 || q.size() != 0) begin
            fails++;
            $display("FAIL bp_release_count delivered=%0d pending=%0d required 3/0", delivered, q.size());
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t held = '0;
        exp_t e;
        logic stalled = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ifun = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            a = pick();
            b = pick();
            #1;
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    fails++;
                    $display("FAIL rand_hold cycle=%0d out_valid=%b obs=%h required 1/%h", cyc, out_valid, obs, held);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_spurious cycle=%0d obs=%h required no result", cyc, obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== vis(e)) begin
                        fails++;
                        $display("FAIL rand_result cycle=%0d obs=%h required=%h", cyc, obs, vis(e));
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(ifun, a, b));
            stalled = out_valid && !out_ready;
            held = obs;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (out_valid) begin
                tests++;
                e = (q.size() != 0) ? q.pop_front() : exp_t'(0);
                if (obs !== vis(e)) begin
                    fails++;
                    $display("FAIL rand_drain obs=%h required=%h", obs, vis(e));
                end
            end
            tick();
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rand_lost pending=%0d required=0", q.size());
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifun = 4'($urandom_range(0, 3)); a = pick(); b = pick();
            tick();
        end
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_full in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || obs !== exp_t'(0) || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_cleared out_valid=%b obs=%h in_ready=%b required 0/0/1", out_valid, obs, in_ready);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_stale cycle=%0d out_valid=%b required=0", cyc, out_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ifun = 4'd0; a = 64'd0; b = 64'd0;
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
